// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a small circular buffer between fetch and decode.
// Entries carry {instruction, address, interrupt flags, predicted-taken}.
// The head entry is shown directly on the outputs (show-ahead); an empty
// queue presents a NOP bubble with zeroed side-band fields.
//
// Handshake: both sides use strict valid/ready. A transfer happens on a
// rising edge only when valid and ready are both high in that cycle and
// flush_i is low. ready_o depends only on registered state (never on
// valid_i or ready_i), so a full queue does not accept a push even when
// the head is popped in the same cycle. flush_i overrides both transfers.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int ADDR_W = 32,
  parameter int INT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic [INST_W-1:0]          inst_i,
  input  logic [ADDR_W-1:0]          inst_addr_i,
  input  logic [INT_W-1:0]           int_flag_i,
  input  logic                       prdt_taken_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [INST_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_addr_o,
  output logic [INT_W-1:0]           int_flag_o,
  output logic                       prdt_taken_o,
  input  logic                       ready_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Bubble presented to decode while the queue is empty.
  localparam logic [INST_W-1:0] INST_NOP = INST_W'(32'h0000_0013);
  localparam logic [INT_W-1:0]  INT_NONE = '0;

  // Storage is deliberately left unreset; occupancy alone decides validity.
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [INT_W-1:0]  int_mem  [DEPTH];
  logic              prdt_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push;
  logic pop;

  // Advance a pointer with explicit wrap at DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status flags come straight from the occupancy register.
  assign ready_o = (cnt_q < CNT_W'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

  assign push = valid_i && ready_o && !flush_i;
  assign pop  = valid_o && ready_i && !flush_i;

  // Next-state for pointers and occupancy; flush empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Write the accepted entry into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= inst_i;
      addr_mem[wr_ptr_q] <= inst_addr_i;
      int_mem[wr_ptr_q]  <= int_flag_i;
      prdt_mem[wr_ptr_q] <= prdt_taken_i;
    end
  end

  // Show-ahead head entry, or the NOP bubble when empty.
  always_comb begin
    inst_o       = INST_NOP;
    inst_addr_o  = '0;
    int_flag_o   = INT_NONE;
    prdt_taken_o = 1'b0;
    if (valid_o) begin
      inst_o       = inst_mem[rd_ptr_q];
      inst_addr_o  = addr_mem[rd_ptr_q];
      int_flag_o   = int_mem[rd_ptr_q];
      prdt_taken_o = prdt_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios followed by random traffic,
// all compared each cycle against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int INT_W  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int E_W    = INST_W + ADDR_W + INT_W + 1;

  logic              clk;
  logic              rst;
  logic              valid_i;
  logic [INST_W-1:0] inst_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [INT_W-1:0]  int_flag_i;
  logic              prdt_taken_i;
  logic              ready_o;
  logic              valid_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic [INT_W-1:0]  int_flag_o;
  logic              prdt_taken_o;
  logic              ready_i;
  logic              flush_i;
  logic [CNT_W-1:0]  count_o;

  // Reference model: entries packed as {inst, addr, int_flag, prdt}.
  logic [E_W-1:0] exp_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  if_id_queue #(
    .DEPTH(DEPTH), .INST_W(INST_W), .ADDR_W(ADDR_W), .INT_W(INT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .int_flag_i   (int_flag_i),
    .prdt_taken_i (prdt_taken_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .int_flag_o   (int_flag_o),
    .prdt_taken_o (prdt_taken_o),
    .ready_i      (ready_i),
    .flush_i      (flush_i),
    .count_o      (count_o)
  );

  // Clock: rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model's queue contents imply.
  task automatic check_all(input string tag);
    logic [E_W-1:0] h;
    int sz;
    sz = exp_q.size();
    check({tag, ":count"}, 64'(count_o), 64'(sz));
    check({tag, ":valid"}, 64'(valid_o), 64'(sz != 0));
    check({tag, ":ready"}, 64'(ready_o), 64'(sz < DEPTH));
    if (sz != 0) begin
      h = exp_q[0];
      check({tag, ":inst"}, 64'(inst_o),       64'(h[E_W-1 -: INST_W]));
      check({tag, ":addr"}, 64'(inst_addr_o),  64'(h[INT_W+ADDR_W : INT_W+1]));
      check({tag, ":int"},  64'(int_flag_o),   64'(h[INT_W:1]));
      check({tag, ":prdt"}, 64'(prdt_taken_o), 64'(h[0]));
    end else begin
      check({tag, ":inst"}, 64'(inst_o),       64'h13);
      check({tag, ":addr"}, 64'(inst_addr_o),  64'h0);
      check({tag, ":int"},  64'(int_flag_o),   64'h0);
      check({tag, ":prdt"}, 64'(prdt_taken_o), 64'h0);
    end
  endtask

  // Model update for one rising edge, from the queue rules alone.
  task automatic model_edge();
    bit do_push, do_pop;
    if (!rst || flush_i) begin
      exp_q.delete();
    end else begin
      do_push = valid_i && (exp_q.size() < DEPTH);
      do_pop  = ready_i && (exp_q.size() > 0);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({inst_i, inst_addr_i, int_flag_i, prdt_taken_i});
    end
  endtask

  // Set inputs for the next cycle; payload side-band fields are random.
  task automatic drive(input logic v, input logic [ADDR_W-1:0] a,
                       input logic rdy, input logic fl);
    valid_i      = v;
    inst_addr_i  = a;
    ready_i      = rdy;
    flush_i      = fl;
    inst_i       = $urandom();
    int_flag_i   = INT_W'($urandom());
    prdt_taken_i = 1'($urandom_range(0, 1));
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  logic [INST_W-1:0] hold_inst;
  logic [ADDR_W-1:0] hold_addr;
  logic [INT_W-1:0]  hold_int;
  logic              hold_prdt;

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;

    // Fill with decode stalled; fifth push must be refused.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ADDR_W'(4 * i), 1'b0, 1'b0);
      step("fill");
      if (i == 3) begin
        check("fill_full_count", 64'(count_o), 64'd4);
        check("fill_full_ready", 64'(ready_o), 64'd0);
        check("fill_head_addr",  64'(inst_addr_o), 64'h0);
      end
    end
    check("fill_5th_ignored", 64'(count_o), 64'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 64'(inst_addr_o), 64'(4 * i));
      drive(1'b0, '0, 1'b1, 1'b0);
      step("drain");
    end
    check("drain_empty_valid", 64'(valid_o), 64'd0);
    check("drain_empty_nop",   64'(inst_o),  64'h13);

    // Streaming: one in, one out each cycle, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      if (i > 0) check("stream_order", 64'(inst_addr_o), 64'(32'h100 + 4 * (i - 1)));
      drive(1'b1, ADDR_W'(32'h100 + 4 * i), 1'b1, 1'b0);
      step("stream");
      check("stream_count", 64'(count_o), 64'd1);
    end
    check("stream_last", 64'(inst_addr_o), 64'h124);
    drive(1'b0, '0, 1'b1, 1'b0);
    step("stream_drain");

    // Flush with a push in the same cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(32'h300 + 4 * i), 1'b0, 1'b0);
      step("pre_flush");
    end
    check("pre_flush_count", 64'(count_o), 64'd3);
    drive(1'b1, ADDR_W'(32'hDEAD), 1'b0, 1'b1);
    step("flush");
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid", 64'(valid_o), 64'd0);
    drive(1'b1, ADDR_W'(32'h200), 1'b0, 1'b0);
    step("post_flush");
    check("flush_dropped", 64'(inst_addr_o), 64'h200);

    // Stall: head must hold while pushes saturate the queue.
    drive(1'b1, ADDR_W'(32'h204), 1'b0, 1'b0);
    step("stall_setup");
    check("stall_setup_count", 64'(count_o), 64'd2);
    hold_inst = inst_o;
    hold_addr = inst_addr_o;
    hold_int  = int_flag_o;
    hold_prdt = prdt_taken_o;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ADDR_W'(32'h208 + 4 * i), 1'b0, 1'b0);
      step("stall");
      check("stall_inst", 64'(inst_o),       64'(hold_inst));
      check("stall_addr", 64'(inst_addr_o),  64'(hold_addr));
      check("stall_int",  64'(int_flag_o),   64'(hold_int));
      check("stall_prdt", 64'(prdt_taken_o), 64'(hold_prdt));
    end
    check("stall_sat", 64'(count_o), 64'd4);

    // Asynchronous reset between edges with three entries held.
    drive(1'b0, '0, 1'b0, 1'b1);
    step("ar_flush");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(32'h400 + 4 * i), 1'b0, 1'b0);
      step("ar_fill");
    end
    check("ar_pre_count", 64'(count_o), 64'd3);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    check("ar_count", 64'(count_o), 64'd0);
    check("ar_valid", 64'(valid_o), 64'd0);
    check("ar_ready", 64'(ready_o), 64'd1);
    check("ar_inst",  64'(inst_o),  64'h13);
    check_all("ar_async");
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, ADDR_W'(32'h500), 1'b1, 1'b0);
    step("ar_first_push");
    check("ar_first_count", 64'(count_o), 64'd1);
    check("ar_first_addr",  64'(inst_addr_o), 64'h500);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom()),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning queue entries; legal values 2, 4 or 8.
REQ-002 SHALL provide parameter INST_W, default 32, meaning instruction width.
REQ-003 SHALL provide parameter ADDR_W, default 32, meaning instruction address width.
REQ-004 SHALL provide parameter INT_W, default 8, meaning interrupt flag width.
REQ-005 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL provide port valid_i, input, 1, fetch entry presented.
REQ-008 SHALL provide port inst_i, input, INST_W, fetched instruction.
REQ-009 SHALL provide port inst_addr_i, input, ADDR_W, fetched instruction address.
REQ-010 SHALL provide port int_flag_i, input, INT_W, peripheral interrupt flags.
REQ-011 SHALL provide port prdt_taken_i, input, 1, branch-predicted-taken flag.
REQ-012 SHALL provide port ready_o, output, 1, queue accepts an entry this cycle.
REQ-013 SHALL provide port valid_o, output, 1, head entry valid.
REQ-014 SHALL provide port inst_o, output, INST_W, head instruction.
REQ-015 SHALL provide port inst_addr_o, output, ADDR_W, head address.
REQ-016 SHALL provide port int_flag_o, output, INT_W, head interrupt flags.
REQ-017 SHALL provide port prdt_taken_o, output, 1, head prediction flag.
REQ-018 SHALL provide port ready_i, input, 1, decode consumes head; low = decode stall.
REQ-019 SHALL provide port flush_i, input, 1, discard all entries (jump or hold at IF level or above).
REQ-020 SHALL provide port count_o, output, log2(DEPTH)+1, current occupancy.

Function
REQ-021 SHALL store entries of {inst, addr, int_flag, prdt_taken} in a circular buffer with write pointer, read pointer and occupancy count.
REQ-022 SHALL push when valid_i=1 and ready_o=1 and flush_i=0.
REQ-023 SHALL pop when valid_o=1 and ready_i=1 and flush_i=0.
REQ-024 SHALL drive ready_o = (count_o < DEPTH), combinationally from state only; no full-queue push-through on simultaneous pop.
REQ-025 SHALL drive valid_o = (count_o != 0).
REQ-026 SHALL present the head entry on data outputs while valid_o=1 (show-ahead; no extra read cycle).
REQ-027 SHALL drive inst_o=INST_NOP (0x00000013), inst_addr_o=0, int_flag_o=INT_NONE (0), prdt_taken_o=0 while valid_o=0.
REQ-028 SHALL have one-cycle latency: entry pushed at edge N appears on outputs with valid_o=1 after edge N; no same-cycle bypass when empty.
REQ-029 SHALL on simultaneous push and pop keep count unchanged and advance both pointers.
REQ-030 SHALL wrap both pointers modulo DEPTH.
REQ-031 SHALL give flush_i priority over push and pop: at the edge, count and both pointers go to 0 and the incoming entry is dropped.
REQ-032 SHALL preserve head entry and outputs unchanged across cycles where ready_i=0 (stall), regardless of further pushes.
REQ-033 SHALL never overflow or underflow: count_o stays within 0..DEPTH.
REQ-034 SHALL not reset storage array contents; only pointers and count are reset.

Reset
REQ-035 SHALL on rst=0, immediately and without clock, set count_o=0 and both pointers=0, giving valid_o=0, ready_o=1 and NOP/zero data outputs.
REQ-036 SHALL discard all in-flight entries when reset asserts mid-operation; first push after release behaves as on an empty queue.

Verification
REQ-037 Fill: DEPTH=4, ready_i=0, push addrs 0x0,0x4,0x8,0xC -> count_o=4, ready_o=0, inst_addr_o=0x0; 5th push ignored.
REQ-038 Drain order: from full, ready_i=1 for 4 cycles -> inst_addr_o 0x0,0x4,0x8,0xC then valid_o=0, inst_o=0x00000013.
REQ-039 Streaming: valid_i=ready_i=1 continuously for 10 entries -> count_o holds 1, every address delivered once in order, pointers wrap without loss.
REQ-040 Flush: count_o=3 with flush_i=1 and valid_i=1 same cycle -> next cycle count_o=0, valid_o=0, flushed-cycle entry absent.
REQ-041 Stall hold: count_o=2, ready_i=0 for 5 cycles with pushes -> inst_o/addr/int_flag/prdt_taken of head constant, count_o saturates at 4.
REQ-042 Async reset: rst low between clock edges with count_o=3 -> count_o=0, valid_o=0, ready_o=1 before next edge.
